// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between four requesters and the
// round-robin arbiter that owns the select of the shared 4:1 data mux.
`timescale 1ns/1ps

interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;

  modport master (output req, input grant, input sel, input valid, input timeout);
  modport slave  (input req, output grant, output sel, output valid, output timeout);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of the shared 4:1 mux select.
// A winner keeps the grant until it drops its request; the released owner
// becomes lowest priority and every hand-over passes through one idle cycle.
// Optional feature macro: MUX4_ARB_TIMEOUT_EN forces a release after
// MAX_HOLD consecutive grant cycles and pulses 'timeout' once afterwards.
`timescale 1ns/1ps

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [3:0] grant_q;
  logic [1:0] sel_q;
  logic       valid_q;
  logic [1:0] winner;
  logic [1:0] idx;

  // Out-of-range hold limits would make the timeout compare unreachable.
  if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD outside 1..2^HOLD_W-1");
  end

  // Rotating priority: scan from the farthest candidate (owner itself) to the
  // nearest (owner+1) so the nearest asserted request wins.
  always_comb begin
    winner = owner;
    idx    = owner;
    for (int k = 4; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (bus.req[idx]) begin
        winner = idx;
      end
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  // Arbitration FSM with hold counter; a forced release after MAX_HOLD cycles
  // behaves like a voluntary one except for the one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 2'd3;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      valid_q   <= 1'b0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|bus.req) begin
            owner    <= winner;
            grant_q  <= 4'b0001 << winner;
            sel_q    <= winner;
            valid_q  <= 1'b1;
            hold_cnt <= HOLD_W'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[owner]) begin
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            state   <= IDLE;
          end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timeout = timeout_q;
`else
  // Arbitration FSM without a hold limit: the owner keeps the mux until it
  // drops its own request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 2'd3;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner   <= winner;
            grant_q <= 4'b0001 << winner;
            sel_q   <= winner;
            valid_q <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[owner]) begin
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.timeout = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenarios with literal expectations plus a
// long randomized request stream, all checked against a behavioural model.
`timescale 1ns/1ps

module tb_mux4_rr_arbiter;
  localparam int MaxHold = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MaxHold), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the mux, for how long, and what sel shows.
  bit         m_busy;
  int         m_owner;
  int         m_held;
  logic [1:0] m_sel;
  bit         m_timeout;

  int vectors;
  int miscompares;

  task automatic modelReset();
    m_busy    = 1'b0;
    m_owner   = 3;
    m_held    = 0;
    m_sel     = 2'd0;
    m_timeout = 1'b0;
  endtask

  task automatic modelStep(input logic [3:0] r);
    int c;
    m_timeout = 1'b0;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_owner + k) % 4;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_sel  = 2'(m_owner);
        m_busy = 1'b1;
        m_held = 1;
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
    end else if (TimeoutEn && m_held == MaxHold) begin
      m_busy    = 1'b0;
      m_timeout = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [3:0] modelGrant();
    return m_busy ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic compareVec(input string name,
                            input logic [3:0] ag, input logic [1:0] as, input logic av, input logic at,
                            input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic et);
    vectors++;
    if (ag !== eg || as !== es || av !== ev || at !== et) begin
      miscompares++;
      $display("[TB] FAIL %s: got grant=%b sel=%b valid=%b timeout=%b, want grant=%b sel=%b valid=%b timeout=%b",
               name, ag, as, av, at, eg, es, ev, et);
    end
  endtask

  // DUT against the model.
  task automatic checkOutput(input string name);
    compareVec(name, bus.grant, bus.sel, bus.valid, bus.timeout,
               modelGrant(), m_sel, m_busy, m_timeout);
  endtask

  // DUT and model both against a hand-computed literal.
  task automatic pinExpect(input string name, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic et);
    compareVec(name, bus.grant, bus.sel, bus.valid, bus.timeout, eg, es, ev, et);
    compareVec({name, "_model"}, modelGrant(), m_sel, m_busy, m_timeout, eg, es, ev, et);
  endtask

  // One clock: drive at negedge, let the edge happen, sample 1ns later.
  task automatic applyStimulus(input logic [3:0] r, input string name);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    modelStep(r);
    #1;
    checkOutput(name);
  endtask

  task automatic stepPin(input logic [3:0] r, input string name, input logic [3:0] eg,
                         input logic [1:0] es, input logic ev, input logic et);
    applyStimulus(r, name);
    pinExpect(name, eg, es, ev, et);
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.req = 4'b1111;
    rst_n   = 1'b0;
    #2;
    modelReset();
    pinExpect("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req = 4'b0000;
    rst_n   = 1'b1;
  endtask

  logic [3:0] seq_req  [12];
  logic [3:0] seq_gnt  [12];
  logic [1:0] seq_sel  [12];
  logic [3:0] cur;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.req     = 4'b0000;
    rst_n       = 1'b1;
    modelReset();

    // Reset state with all requests high.
    doReset();

    // Single requester 2 held for three edges, then drops.
    stepPin(4'b0100, "single_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    stepPin(4'b0100, "single_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    stepPin(4'b0100, "single_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    stepPin(4'b0000, "single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    // All four requesting, each owner drops its bit after two grant cycles.
    doReset();
    seq_req = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1100,
                4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    seq_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    seq_sel = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 12; i++) begin
      stepPin(seq_req[i], $sformatf("rr_%0d", i), seq_gnt[i], seq_sel[i], |seq_gnt[i], 1'b0);
    end

    // Owner 1 releases while 3 and 0 request: 3 must come before 0.
    doReset();
    stepPin(4'b0010, "skip_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    stepPin(4'b1001, "skip_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    stepPin(4'b1001, "skip_next", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Requesters 1 and 2 held continuously.
    doReset();
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int i = 0; i < MaxHold; i++) begin
      stepPin(4'b0110, $sformatf("hold_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    stepPin(4'b0110, "forced_idle", 4'b0000, 2'd1, 1'b0, 1'b1);
    stepPin(4'b0110, "after_tmo", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
    for (int i = 0; i < MaxHold + 3; i++) begin
      stepPin(4'b0110, $sformatf("hold_%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    stepPin(4'b0100, "hold_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    stepPin(4'b0100, "hold_next", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

    // Asynchronous reset between edges while requester 3 owns the mux.
    doReset();
    stepPin(4'b1000, "pre_async", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    modelReset();
    pinExpect("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stepPin(4'b0010, "post_async", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Randomized request stream with sticky requests so grants last a while.
    doReset();
    cur = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur = 4'($urandom_range(0, 15));
      end
      applyStimulus(cur, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexer (data1..data4 → data_out) among four requesters. It grants exclusive ownership to one requester at a time and drives the mux `sel` lines so that the owner's data reaches `data_out`. Each grant is held for a multi-cycle transaction until the owner releases it. The block sits directly in front of the Mux1bit4to1 datapath and is the only source of its select.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per transaction; only used when the timeout feature is compiled in. Legal range is 1..(2^HOLD_W − 1).
- `HOLD_W`, default 4: width of the hold counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request per requester; bit i corresponds to mux input data(i+1).
- `grant`, output, 4: one-hot registered grant, or all zero.
- `sel`, output, 2: mux select, equal to the owner index; connects to the mux `sel` port.
- `valid`, output, 1: high while `grant` is non-zero; qualifies `data_out`.
- `timeout`, output, 1: one-cycle pulse marking a forced release.

## Operation
- The FSM has two states, IDLE and GRANT. The registered `owner` (2 bits) tracks the last granted index; it resets to 3, so requester 0 has first priority.
- **IDLE:**
  - `grant`=0 and `valid`=0.
  - If `req`≠0, pick the first asserted bit in the order owner+1, owner+2, owner+3, owner (mod 4).
  - Load `owner`, `grant`=onehot(winner), `sel`=winner, `valid`=1, and go to GRANT.
- **GRANT:**
  - Hold `grant`, `sel` and `valid`.
  - If `req[owner]`=0 at a rising edge, return to IDLE with `grant`=0 and `valid`=0.
  - Requests from other requesters never preempt the owner.
- Consecutive grants are always separated by at least one IDLE cycle with `grant`=0, so the arbiter never switches owner back-to-back.
- `sel` is not cleared in IDLE; it keeps the last owner index so the mux input stays stable.
- The just-released owner gets lowest priority in the next arbitration, which prevents starvation.
- `grant` is always one-hot or zero. `valid` == |grant. `sel` == index of the set bit whenever `valid`=1.
- **Reset values:** `grant`=0000, `sel`=00, `valid`=0, `timeout`=0, state=IDLE, `owner`=3, hold counter=0.
- **Reset mid-operation:** all outputs clear immediately and asynchronously; after release, arbitration restarts from requester 0's priority.
- `req` bits change only in synchronous logic and must be stable around the clock edge. Bits deasserted in IDLE are simply not considered.

## Timing
- Grant latency: a `req` sampled high at edge k in IDLE gives `grant` high after edge k.
- Release latency: `req[owner]` sampled low at edge k gives `grant` low after edge k.
- The next grant comes after edge k+1 at the earliest.
- Minimum turnaround between two owners is one idle cycle.
- Single-owner throughput: a transaction of N cycles occupies N grant cycles plus one idle cycle.

## Configuration
- Macro: `MUX4_ARB_TIMEOUT_EN`.
- **Defined:**
  - The hold counter loads 1 on entry to GRANT and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD` and `req[owner]` is still 1, the next edge forces IDLE. `grant` has then been high exactly `MAX_HOLD` cycles.
  - `timeout` pulses high for the first IDLE cycle after a forced release only.
  - `owner` updates as for a normal release, so the preempted requester drops to lowest priority. If it still requests, it re-competes normally.
  - A voluntary release on the same edge as expiry counts as a normal release, with `timeout`=0.
- **Undefined:**
  - No counter logic is built.
  - `timeout` is tied to 0.
  - A grant is held indefinitely until `req[owner]` drops.

## Test plan
- Reset with `req`=1111 and `rst_n`=0 → `grant`=0000, `sel`=00, `valid`=0, `timeout`=0.
- `req`=0100 held 3 cycles after reset → `grant`=0100, `sel`=10, `valid`=1 for exactly 3 cycles starting the cycle after the first sampled edge. `grant`=0 the cycle after `req` drops.
- `req`=1111 after reset, each owner dropping its bit after 2 grant cycles → grant order 0001, 0010, 0100, 1000, with one `grant`=0000 cycle between each.
- Owner 1 releases while `req`=1001 → next grant is 1000 (`sel`=11), not 0001.
- With `MUX4_ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=0110 held continuously:
  - `grant`=0010 for exactly 4 cycles.
  - Then one idle cycle with `timeout`=1.
  - Then `grant`=0100.
  - Without the macro, `grant`=0010 persists until `req[1]` drops.
- `rst_n` pulsed low mid-grant, between clock edges → `grant`, `valid` and `sel` clear immediately, with no clock edge needed. After release, `req`=0010 gives `grant`=0010.
